// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------
// ram_arb_pkg: shared types and defaults for the RAM port-A arbiter
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    READ_DATA = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// ----------------------------------------------------------------
// rr_arbiter2: combinational two-way round-robin pick
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    // On a tie the requester that did not win last time goes first.
    if (req0 && req1) begin
      gnt_id = ~last;
    end else if (req1) begin
      gnt_id = REQ1;
    end else begin
      gnt_id = REQ0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------
// ram_port_arbiter: shares RAM port A between two requesters
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t              state;
  logic                owner;
  logic                last;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic                gnt_valid;
  logic                gnt_id;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter2 u_rr_arbiter2 (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign sel_we    = (gnt_id == REQ1) ? we1    : we0;
  assign sel_addr  = (gnt_id == REQ1) ? addr1  : addr0;
  assign sel_wdata = (gnt_id == REQ1) ? wdata1 : wdata0;

  // The RAM only ever sees the latched request, never the live inputs.
  assign ram_addr = lat_addr;
  assign ram_din  = lat_wdata;
  assign rdata    = (state == READ_DATA) ? ram_dout : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= REQ0;
      last      <= REQ1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ram_we    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner     <= gnt_id;
            last      <= gnt_id;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            state     <= ACCESS;
            busy      <= 1'b1;
            // A write completes in ACCESS, so its strobe and ack are set up now.
            ram_we    <= sel_we;
            ack0      <= sel_we & (gnt_id == REQ0);
            ack1      <= sel_we & (gnt_id == REQ1);
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= READ_DATA;
            busy  <= 1'b1;
            ack0  <= (owner == REQ0);
            ack1  <= (owner == REQ1);
          end
        end
        READ_DATA: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------
// tb_ram_port_arbiter: directed bench with a timeline model of the arbiter
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ram_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int NCYC = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] rdata, ram_din, ram_dout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Port A of the RAM: write-enable commit, registered read.
  logic [DW-1:0] ram_mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each grant schedules the expected outputs of the following periods.
  logic [DW-1:0] mdl_mem [0:1023];
  bit            e_busy [0:NCYC-1];
  bit            e_we   [0:NCYC-1];
  bit            e_ack0 [0:NCYC-1];
  bit            e_ack1 [0:NCYC-1];
  bit            e_acc  [0:NCYC-1];
  bit [AW-1:0]   e_addr [0:NCYC-1];
  bit [DW-1:0]   e_din  [0:NCYC-1];
  bit [DW-1:0]   e_rdat [0:NCYC-1];
  int            free_at = 0;
  bit            m_last  = 1'b1;
  bit            pend_v  = 1'b0;
  int            pend_cyc;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;

  always @(posedge clk) begin : model
    int p; bit id; bit w; logic [AW-1:0] a; logic [DW-1:0] d;
    p = cyc;
    if (!rst) begin
      free_at = p + 1; m_last = 1'b1; pend_v = 1'b0;
    end else begin
      if (pend_v && pend_cyc == p) begin
        mdl_mem[pend_a] = pend_d; pend_v = 1'b0;
      end
      if (p >= free_at && (req0 || req1)) begin
        id = (req0 && req1) ? ~m_last : req1;
        w  = id ? we1 : we0;
        a  = id ? addr1 : addr0;
        d  = id ? wdata1 : wdata0;
        m_last = id;
        e_busy[p+1] = 1'b1; e_acc[p+1] = 1'b1; e_addr[p+1] = a; e_din[p+1] = d;
        if (w) begin
          e_we[p+1] = 1'b1;
          if (id) e_ack1[p+1] = 1'b1; else e_ack0[p+1] = 1'b1;
          pend_v = 1'b1; pend_cyc = p + 1; pend_a = a; pend_d = d;
          free_at = p + 2;
        end else begin
          e_busy[p+2] = 1'b1;
          if (id) e_ack1[p+2] = 1'b1; else e_ack0[p+2] = 1'b1;
          e_rdat[p+2] = mdl_mem[a];
          free_at = p + 3;
        end
      end
    end
    cyc = p + 1;
  end

  always @(negedge clk) begin : compare
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        e_busy[cyc+k] = 1'b0; e_we[cyc+k] = 1'b0; e_ack0[cyc+k] = 1'b0;
        e_ack1[cyc+k] = 1'b0; e_acc[cyc+k] = 1'b0; e_rdat[cyc+k] = '0;
      end
      free_at = cyc; m_last = 1'b1; pend_v = 1'b0;
      check("rst_outputs", {ram_we, ack0, ack1, busy, rdata, ram_addr}, 32'd0);
      check("rst_din", 32'(ram_din), 32'd0);
    end else begin
      check("busy",   32'(busy),   32'(e_busy[cyc]));
      check("ram_we", 32'(ram_we), 32'(e_we[cyc]));
      check("ack0",   32'(ack0),   32'(e_ack0[cyc]));
      check("ack1",   32'(ack1),   32'(e_ack1[cyc]));
      check("rdata",  32'(rdata),  32'(e_rdat[cyc]));
      if (e_acc[cyc]) begin
        check("ram_addr", 32'(ram_addr), 32'(e_addr[cyc]));
        check("ram_din",  32'(ram_din),  32'(e_din[cyc]));
      end
    end
  end

  task automatic do_access(input bit id, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit drop_early,
                           output int lat, output logic [DW-1:0] rd);
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else    begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    lat = 0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (drop_early && n == 2) begin
        if (id) req1 = 1'b0; else req0 = 1'b0;
      end
      if ((id ? ack1 : ack0) === 1'b1) begin
        lat = n; rd = rdata; break;
      end
    end
    if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat; logic [DW-1:0] rd; int order[$]; int exp_order [4];
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = DW'(i * 7) ^ 16'h1111;
      mdl_mem[i] = DW'(i * 7) ^ 16'h1111;
    end
    ram_mem[0]     = 16'h5A5A; mdl_mem[0]     = 16'h5A5A;
    ram_mem[10'h7] = 16'h00AA; mdl_mem[10'h7] = 16'h00AA;
    ram_mem[10'h20] = 16'h0001; mdl_mem[10'h20] = 16'h0001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Single write
    do_access(1'b0, 1'b1, 10'h005, 16'hBEEF, 1'b0, lat, rd);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'h005);
    check("wr_ram_din", 32'(ram_din), 32'hBEEF);
    check("wr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("wr_busy_after", 32'(busy), 32'd0);

    // Read-back
    do_access(1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, lat, rd);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_data", 32'(rd), 32'hBEEF);

    // Contention: both requesters hold writes continuously
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h010; wdata0 = 16'h0A0A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h011; wdata1 = 16'h0B0B;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    check("contention_count_ok", 32'(order.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) check("contention_order", 32'(order[i]), 32'(exp_order[i]));
    do_access(1'b0, 1'b0, 10'h010, 16'h0000, 1'b0, lat, rd);
    check("contention_rd0", 32'(rd), 32'h0A0A);
    do_access(1'b1, 1'b0, 10'h011, 16'h0000, 1'b0, lat, rd);
    check("contention_rd1", 32'(rd), 32'h0B0B);

    // Boundary address
    do_access(1'b0, 1'b1, 10'h3FF, 16'h1234, 1'b0, lat, rd);
    do_access(1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, lat, rd);
    check("top_addr_rd", 32'(rd), 32'h1234);
    do_access(1'b1, 1'b0, 10'h000, 16'h0000, 1'b0, lat, rd);
    check("addr0_unchanged", 32'(rd), 32'h5A5A);

    // Request dropped right after grant
    do_access(1'b0, 1'b0, 10'h007, 16'h0000, 1'b1, lat, rd);
    check("drop_latency", 32'(lat), 32'd3);
    check("drop_rd", 32'(rd), 32'h00AA);

    // Reset during the ACCESS cycle of a write
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h020; wdata0 = 16'hFFFF;
    @(posedge clk); #2;
    rst = 1'b0; req0 = 1'b0;
    #1;
    check("abort_ram_we", 32'(ram_we), 32'd0);
    check("abort_ack0", 32'(ack0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("abort_no_ack", 32'(ack0), 32'd0);
    end
    do_access(1'b1, 1'b0, 10'h020, 16'h0000, 1'b0, lat, rd);
    check("abort_latency", 32'(lat), 32'd3);
    check("abort_old_value", 32'(rd), 32'h0001);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
